// File: rtl/bp_be_mul_sched_pkg.sv
// Shared backend definitions for the multiply scheduler.
// Holds default latency and widths, the request struct, and the queue-depth helper.
package bp_be_mul_sched_pkg;

    localparam int unsigned mul_lat_default_lp = 3;
    localparam int unsigned mul_els_default_lp = mul_lat_default_lp + 2;
    localparam int unsigned mul_tag_width_lp   = 5;
    localparam int unsigned mul_op_width_lp    = 4;

    typedef struct packed {
        logic [mul_op_width_lp-1:0]  op;
        logic [mul_tag_width_lp-1:0] tag;
    } bp_be_mul_req_s;

    // Two extra slots cover the result still in the last stage plus the one being dequeued.
    function automatic int unsigned mul_els(input int unsigned lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/bp_be_mul_tag_fifo.sv
// Circular tag FIFO with read/write pointers and wrap bits; depth need not be a power of two.
module bp_be_mul_tag_fifo #(
    parameter int unsigned els_p   = 5,
    parameter int unsigned width_p = 5
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    typedef logic [ptr_w_lp-1:0] ptr_t;
    localparam ptr_t last_lp = ptr_t'(els_p - 1);

    logic [width_p-1:0] mem_r [els_p];
    ptr_t rptr_r, wptr_r, rptr_n, wptr_n;
    logic rwrap_r, wwrap_r, rwrap_n, wwrap_n;
    logic ptr_eq;

    assign ptr_eq = (rptr_r == wptr_r);
    assign v_o    = !(ptr_eq && (rwrap_r == wwrap_r));
    assign full_o = ptr_eq && (rwrap_r != wwrap_r);
    assign data_o = mem_r[rptr_r];

    always_comb begin
        rptr_n  = rptr_r;
        rwrap_n = rwrap_r;
        wptr_n  = wptr_r;
        wwrap_n = wwrap_r;
        if (deq_i) begin
            rptr_n  = (rptr_r == last_lp) ? '0 : rptr_r + ptr_t'(1);
            rwrap_n = rwrap_r ^ (rptr_r == last_lp);
        end
        if (enq_i) begin
            wptr_n  = (wptr_r == last_lp) ? '0 : wptr_r + ptr_t'(1);
            wwrap_n = wwrap_r ^ (wptr_r == last_lp);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            rwrap_r <= 1'b0;
            wwrap_r <= 1'b0;
        end else begin
            rptr_r  <= rptr_n;
            wptr_r  <= wptr_n;
            rwrap_r <= rwrap_n;
            wwrap_r <= wwrap_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            mem_r[wptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/bp_be_mul_sched.sv
// Multiply issue scheduler: credit-gated accept, fixed-latency valid/tag pipe with
// two kill points, and a result-tag queue that can never overflow.
module bp_be_mul_sched
    import bp_be_mul_sched_pkg::*;
#(
    parameter int unsigned lat_p       = mul_lat_default_lp,
    parameter int unsigned tag_width_p = mul_tag_width_lp,
    parameter int unsigned op_width_p  = mul_op_width_lp
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   req_v_i,
    output logic                   req_ready_o,
    input  logic [op_width_p-1:0]  req_op_i,
    input  logic [tag_width_p-1:0] req_tag_i,
    input  logic                   kill_ex1_i,
    input  logic                   kill_ex2_i,
    output logic                   mul_v_o,
    output logic [op_width_p-1:0]  mul_op_o,
    output logic [lat_p-1:0]       stage_v_o,
    output logic                   res_v_o,
    output logic [tag_width_p-1:0] res_tag_o,
    input  logic                   res_yumi_i,
    output logic                   busy_o
);

    localparam int unsigned els_lp      = mul_els(lat_p);
    localparam int unsigned credit_w_lp = $clog2(els_lp + 1);
    typedef logic [credit_w_lp-1:0] credit_t;

    credit_t credit_r, credit_n;
    logic [lat_p-1:0] stage_v_r, stage_v_n, kill_v, live_v;
    logic [tag_width_p-1:0] stage_tag_r [lat_p];
    logic accept, enq, fifo_full;

    // Credits count every op in flight or queued, so ready depends on registers only.
    assign req_ready_o = (credit_r < credit_t'(els_lp));
    assign accept      = req_v_i & req_ready_o;
    assign mul_v_o     = accept;
    assign mul_op_o    = req_op_i;
    assign stage_v_o   = stage_v_r;
    assign busy_o      = (|stage_v_r) | res_v_o;

    always_comb begin
        kill_v    = '0;
        kill_v[0] = kill_ex1_i & stage_v_r[0];
        kill_v[1] = kill_ex2_i & stage_v_r[1];
        live_v    = stage_v_r & ~kill_v;
        stage_v_n = {live_v[lat_p-2:0], accept};
        enq       = live_v[lat_p-1];
        credit_n  = credit_r + credit_t'(accept) - credit_t'(res_yumi_i)
                  - credit_t'(kill_v[0]) - credit_t'(kill_v[1]);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage_v_r <= '0;
            credit_r  <= '0;
        end else begin
            stage_v_r <= stage_v_n;
            credit_r  <= credit_n;
        end
    end

    always_ff @(posedge clk_i) begin
        stage_tag_r[0] <= req_tag_i;
        for (int unsigned i = 1; i < lat_p; i++) begin
            stage_tag_r[i] <= stage_tag_r[i-1];
        end
    end

    bp_be_mul_tag_fifo #(
        .els_p   (els_lp),
        .width_p (tag_width_p)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (enq),
        .data_i    (stage_tag_r[lat_p-1]),
        .deq_i     (res_yumi_i),
        .v_o       (res_v_o),
        .data_o    (res_tag_o),
        .full_o    (fifo_full)
    );

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        res_yumi_i |-> res_v_o);
    no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(enq && fifo_full));

endmodule

// File: tb/tb_bp_be_mul_sched.sv
// Directed bench for bp_be_mul_sched: expected tags are queued at issue time and a
// negedge monitor pops and compares them whenever a result is consumed.
module tb_bp_be_mul_sched;
    import bp_be_mul_sched_pkg::*;

    localparam int unsigned lat_lp = 3;

    logic                        clk, reset_n;
    logic                        req_v, req_ready, kill_ex1, kill_ex2;
    logic [mul_op_width_lp-1:0]  req_op, mul_op;
    logic [mul_tag_width_lp-1:0] req_tag, res_tag;
    logic                        mul_v, res_v, res_yumi, busy, yumi_en;
    logic [lat_lp-1:0]           stage_v;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    assign res_yumi = yumi_en & res_v;

    bp_be_mul_sched #(
        .lat_p       (lat_lp),
        .tag_width_p (mul_tag_width_lp),
        .op_width_p  (mul_op_width_lp)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .req_v_i     (req_v),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_tag_i   (req_tag),
        .kill_ex1_i  (kill_ex1),
        .kill_ex2_i  (kill_ex2),
        .mul_v_o     (mul_v),
        .mul_op_o    (mul_op),
        .stage_v_o   (stage_v),
        .res_v_o     (res_v),
        .res_tag_o   (res_tag),
        .res_yumi_i  (res_yumi),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input bp_be_mul_req_s r);
        req_v   = v;
        req_op  = r.op;
        req_tag = r.tag;
    endtask

    task automatic drain(input int max_cycles);
        yumi_en = 1'b1;
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) next();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n && res_v && res_yumi) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got tag %0d, expected none", res_tag);
            end else begin
                check("result_tag", 32'(res_tag), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int acc, hits, first, last, drops;
        reset_n  = 1'b0;
        yumi_en  = 1'b0;
        kill_ex1 = 1'b0;
        kill_ex2 = 1'b0;
        drive(1'b1, '{op: 4'h3, tag: 5'd0});
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_res_v", 32'(res_v), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stage_v", 32'(stage_v), 32'd0);
        check("rst_mul_v", 32'(mul_v), 32'd1);
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        next();
        next();
        reset_n = 1'b1;

        // Single op, tag 7
        next();
        drive(1'b1, '{op: 4'h9, tag: 5'd7});
        exp_q.push_back(7);
        @(negedge clk);
        check("s1_mul_v", 32'(mul_v), 32'd1);
        check("s1_mul_op", 32'(mul_op), 32'h9);
        next();
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        @(negedge clk);
        check("s1_stage_c1", 32'(stage_v), 32'b001);
        next();
        next();
        @(negedge clk);
        check("s1_res_v_c3", 32'(res_v), 32'd0);
        check("s1_stage_c3", 32'(stage_v), 32'b100);
        next();
        yumi_en = 1'b1;
        @(negedge clk);
        check("s1_res_v_c4", 32'(res_v), 32'd1);
        check("s1_res_tag_c4", 32'(res_tag), 32'd7);
        next();
        yumi_en = 1'b0;
        @(negedge clk);
        check("s1_busy_after", 32'(busy), 32'd0);

        // Back-to-back tags 1..10 with yumi held
        next();
        yumi_en = 1'b1;
        hits = 0; first = -1; last = -1; drops = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) begin
                drive(1'b1, '{op: 4'h1, tag: 5'(c + 1)});
                exp_q.push_back(c + 1);
            end else begin
                drive(1'b0, '{op: 4'h0, tag: 5'd0});
            end
            @(negedge clk);
            if (c < 10 && !req_ready) drops++;
            if (res_v) begin
                hits++;
                if (first < 0) first = c;
                last = c;
            end
            next();
        end
        check("s2_ready_drops", 32'(drops), 32'd0);
        check("s2_result_count", 32'(hits), 32'd10);
        check("s2_consecutive", 32'(last - first), 32'd9);
        check("s2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Tags 3,4,5 with both kills in cycle 3
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, '{op: 4'h2, tag: 5'(c + 3)});
            if (c == 0) exp_q.push_back(3);
            next();
        end
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        kill_ex1 = 1'b1;
        kill_ex2 = 1'b1;
        @(negedge clk);
        check("s3_stage_c3", 32'(stage_v), 32'b111);
        check("s3_credit_c3", 32'(dut.credit_r), 32'd3);
        next();
        kill_ex1 = 1'b0;
        kill_ex2 = 1'b0;
        @(negedge clk);
        check("s3_credit_c4", 32'(dut.credit_r), 32'd1);
        check("s3_res_v_c4", 32'(res_v), 32'd1);
        drain(10);
        for (int i = 0; i < 6; i++) next();
        check("s3_credit_end", 32'(dut.credit_r), 32'd0);
        check("s3_busy_end", 32'(busy), 32'd0);

        // Yumi low: five accepts, then one yumi frees one slot
        yumi_en = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, '{op: 4'h4, tag: 5'(11 + c)});
            if (c < 5) exp_q.push_back(11 + c);
            @(negedge clk);
            if (mul_v) acc++;
            if (c == 7) check("s4_ready_low", 32'(req_ready), 32'd0);
            next();
        end
        check("s4_accepts", 32'(acc), 32'd5);
        drive(1'b1, '{op: 4'h4, tag: 5'd19});
        yumi_en = 1'b1;
        @(negedge clk);
        check("s4_no_accept_on_yumi", 32'(mul_v), 32'd0);
        next();
        yumi_en = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, '{op: 4'h4, tag: 5'(20 + c)});
            if (c == 0) exp_q.push_back(20);
            @(negedge clk);
            if (mul_v) acc++;
            next();
        end
        check("s4_one_more_accept", 32'(acc), 32'd1);
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        drain(20);
        next();
        yumi_en = 1'b0;

        // Accept, dequeue and kill_ex1 in one cycle
        drive(1'b1, '{op: 4'h5, tag: 5'd20});
        exp_q.push_back(20);
        next();
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        next();
        next();
        drive(1'b1, '{op: 4'h5, tag: 5'd21});
        next();
        drive(1'b1, '{op: 4'h5, tag: 5'd22});
        exp_q.push_back(22);
        kill_ex1 = 1'b1;
        yumi_en  = 1'b1;
        @(negedge clk);
        check("s6_credit_before", 32'(dut.credit_r), 32'd2);
        check("s6_stage_before", 32'(stage_v), 32'b001);
        check("s6_res_v", 32'(res_v), 32'd1);
        next();
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        kill_ex1 = 1'b0;
        @(negedge clk);
        check("s6_credit_after", 32'(dut.credit_r), 32'd1);
        drain(10);
        for (int i = 0; i < 4; i++) next();
        yumi_en = 1'b0;

        // Reset with three ops in flight
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, '{op: 4'h6, tag: 5'(30 + c)});
            next();
        end
        drive(1'b0, '{op: 4'h0, tag: 5'd0});
        reset_n = 1'b0;
        #1;
        check("s5_rst_ready", 32'(req_ready), 32'd1);
        check("s5_rst_res_v", 32'(res_v), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_stage_v", 32'(stage_v), 32'd0);
        check("s5_rst_credit", 32'(dut.credit_r), 32'd0);
        next();
        next();
        reset_n = 1'b1;
        yumi_en = 1'b1;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_v) hits++;
            next();
        end
        check("s5_no_result_after_reset", 32'(hits), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
